prog_counter: RTL and testbench

Parametrised synchronous counter, the successor to the fixed 4-bit load/count counter used for the program counter and timer paths. Adds configurable width and modulus, up/down direction, synchronous clear, three terminal-count modes (wrap, saturate, auto-reload), a cascadable active-low carry chain and a sticky overflow flag. It drops in wherever the CPU or peripherals need a loadable counter, and several instances can be chained through `ENT_N`/`RCO_N` to form wider counters.

---
 rtl/prog_counter_if.sv | 27 ++
 rtl/prog_counter.sv | 74 +++++++
 tb/tb_prog_counter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/prog_counter_if.sv
// Control and status bundle of a prog_counter instance. Signal names match the
// program-counter and timer netlists this counter plugs into.
interface prog_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             CLR_N;
  logic             ENB_LD;
  logic [WIDTH-1:0] DIN;
  logic             ENP_N;
  logic             ENT_N;
  logic             UP;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             RCO_N;
  logic             OVF;

  modport master (
    output CLR_N, ENB_LD, DIN, ENP_N, ENT_N, UP, MODE,
    input  Q, TC, RCO_N, OVF
  );

  modport slave (
    input  CLR_N, ENB_LD, DIN, ENP_N, ENT_N, UP, MODE,
    output Q, TC, RCO_N, OVF
  );
endinterface

// File: rtl/prog_counter.sv
// Loadable up/down counter, modulus MAX+1, with wrap/saturate/auto-reload terminal
// behaviour, an active-low cascade carry chain and a sticky overflow flag.
module prog_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          CLK,
  input  logic          RST,
  prog_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ModeWrap     = 2'b00,
    ModeSaturate = 2'b01,
    ModeReload   = 2'b10,
    ModeWrapAlt  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] din_clamped;
  logic             tc;
  logic             count_en;

  assign din_clamped = (bus.DIN > MAX) ? MAX : bus.DIN;
  assign tc          = bus.UP ? (q_q == MAX) : (q_q == '0);
  assign count_en    = ~bus.ENP_N & ~bus.ENT_N;

  always_comb begin
    q_d   = q_q;
    rld_d = rld_q;
    ovf_d = ovf_q;
    if (!bus.CLR_N) begin
      // Clear beats load and leaves the reload register alone.
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (!bus.ENB_LD) begin
      q_d   = din_clamped;
      rld_d = din_clamped;
      ovf_d = 1'b0;
    end else if (count_en) begin
      if (tc) begin
        ovf_d = 1'b1;
        case (mode_e'(bus.MODE))
          ModeSaturate: q_d = q_q;
          ModeReload:   q_d = rld_q;
          default:      q_d = bus.UP ? '0 : MAX;
        endcase
      end else begin
        q_d = bus.UP ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q_q   <= RESET_VAL;
      rld_q <= RESET_VAL;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rld_q <= rld_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.TC    = tc;
  assign bus.RCO_N = ~(tc & ~bus.ENT_N);
  assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed checks of prog_counter: one MAX=9 instance plus a two-stage 4-bit cascade.
module tb_prog_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prog_counter_if #(.WIDTH(4)) a_if ();
  prog_counter_if #(.WIDTH(4)) lo_if ();
  prog_counter_if #(.WIDTH(4)) hi_if ();

  prog_counter #(.WIDTH(4), .MAX(4'd9), .RESET_VAL(4'd0)) u_dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (a_if.slave)
  );

  prog_counter #(.WIDTH(4)) u_lo (
    .CLK (clk),
    .RST (rst_n),
    .bus (lo_if.slave)
  );

  prog_counter #(.WIDTH(4)) u_hi (
    .CLK (clk),
    .RST (rst_n),
    .bus (hi_if.slave)
  );

  assign hi_if.ENT_N = lo_if.RCO_N;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_up [4]  = '{4'd8, 4'd9, 4'd0, 4'd1};
  logic [3:0] exp_ar [6]  = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd5, 4'd6};
  logic [7:0] exp_cas [3] = '{8'h0F, 8'h10, 8'h11};

  initial begin
    rst_n        = 1'b0;
    a_if.CLR_N   = 1'b1; a_if.ENB_LD  = 1'b1; a_if.DIN = 4'd0;
    a_if.ENP_N   = 1'b1; a_if.ENT_N   = 1'b1; a_if.UP  = 1'b1; a_if.MODE = 2'b00;
    lo_if.CLR_N  = 1'b1; lo_if.ENB_LD = 1'b1; lo_if.DIN = 4'd0;
    lo_if.ENP_N  = 1'b1; lo_if.ENT_N  = 1'b0; lo_if.UP  = 1'b1; lo_if.MODE = 2'b00;
    hi_if.CLR_N  = 1'b1; hi_if.ENB_LD = 1'b1; hi_if.DIN = 4'd0;
    hi_if.ENP_N  = 1'b1; hi_if.UP     = 1'b1; hi_if.MODE = 2'b00;

    #2;
    check("rst_q", a_if.Q, 0);
    check("rst_ovf", a_if.OVF, 0);
    check("rst_tc", a_if.TC, 0);
    check("rst_rco", a_if.RCO_N, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Load above MAX clamps.
    a_if.DIN = 4'd12; a_if.ENB_LD = 1'b0;
    tick();
    check("load_clamp_q", a_if.Q, 9);
    check("load_clamp_tc", a_if.TC, 1);
    a_if.ENB_LD = 1'b1;

    // Wrap up from 7, then down from 1.
    a_if.DIN = 4'd7; a_if.ENB_LD = 1'b0;
    tick();
    check("load7_q", a_if.Q, 7);
    a_if.ENB_LD = 1'b1; a_if.ENP_N = 1'b0; a_if.ENT_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("wrap_up_q%0d", i), a_if.Q, exp_up[i]);
      if (i == 1) begin
        check("wrap_up_tc", a_if.TC, 1);
        check("wrap_up_rco", a_if.RCO_N, 0);
        check("wrap_up_ovf_pre", a_if.OVF, 0);
      end
      if (i == 2) check("wrap_up_ovf", a_if.OVF, 1);
    end
    a_if.UP = 1'b0;
    tick();
    check("wrap_dn_q0", a_if.Q, 0);
    check("wrap_dn_tc", a_if.TC, 1);
    tick();
    check("wrap_dn_q1", a_if.Q, 9);

    // Load with count enabled: load wins and clears OVF.
    a_if.UP = 1'b1; a_if.MODE = 2'b01; a_if.DIN = 4'd8; a_if.ENB_LD = 1'b0;
    tick();
    check("load_vs_cnt_q", a_if.Q, 8);
    check("load_vs_cnt_ovf", a_if.OVF, 0);
    a_if.ENB_LD = 1'b1;

    // Saturate.
    tick();
    check("sat_q0", a_if.Q, 9);
    check("sat_ovf0", a_if.OVF, 0);
    tick();
    check("sat_q1", a_if.Q, 9);
    check("sat_ovf1", a_if.OVF, 1);
    tick();
    check("sat_q2", a_if.Q, 9);
    a_if.DIN = 4'd3; a_if.ENB_LD = 1'b0;
    tick();
    check("sat_load_q", a_if.Q, 3);
    check("sat_load_ovf", a_if.OVF, 0);

    // Auto-reload from 5.
    a_if.MODE = 2'b10; a_if.DIN = 4'd5;
    tick();
    check("ar_load_q", a_if.Q, 5);
    a_if.ENB_LD = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("ar_q%0d", i), a_if.Q, exp_ar[i]);
      if (i == 3) check("ar_ovf_pre", a_if.OVF, 0);
      if (i == 4) check("ar_ovf", a_if.OVF, 1);
    end

    // ENT_N gates both counting and carry out.
    a_if.ENP_N = 1'b1; a_if.DIN = 4'd9; a_if.ENB_LD = 1'b0;
    tick();
    a_if.ENB_LD = 1'b1; a_if.ENP_N = 1'b0; a_if.ENT_N = 1'b1;
    tick();
    check("gate_q", a_if.Q, 9);
    check("gate_tc", a_if.TC, 1);
    check("gate_rco", a_if.RCO_N, 1);
    check("gate_ovf", a_if.OVF, 0);
    a_if.ENP_N = 1'b1; a_if.ENT_N = 1'b0;
    #1;
    check("gate_rco_comb", a_if.RCO_N, 0);
    tick();
    check("enp_hold_q", a_if.Q, 9);

    // Clear beats load; RLD must still hold 9.
    a_if.CLR_N = 1'b0; a_if.ENB_LD = 1'b0; a_if.DIN = 4'd4;
    tick();
    check("clr_q", a_if.Q, 0);
    check("clr_ovf", a_if.OVF, 0);
    a_if.CLR_N = 1'b1; a_if.ENB_LD = 1'b1; a_if.MODE = 2'b10; a_if.UP = 1'b0;
    a_if.ENP_N = 1'b0;
    tick();
    check("rld_kept_q", a_if.Q, 9);
    check("rld_kept_ovf", a_if.OVF, 1);
    // Reload value equal to terminal: Q stays put.
    a_if.UP = 1'b1;
    tick();
    check("ar_term_q", a_if.Q, 9);
    a_if.MODE = 2'b11;
    tick();
    check("mode11_wrap_q", a_if.Q, 0);

    // Asynchronous reset mid-count.
    a_if.MODE = 2'b00;
    tick();
    check("pre_rst_q", a_if.Q, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", a_if.Q, 0);
    check("async_rst_ovf", a_if.OVF, 0);
    rst_n = 1'b1;
    a_if.ENP_N = 1'b1;

    // Cascade two 4-bit stages from 0x0E.
    @(negedge clk);
    lo_if.DIN = 4'hE; hi_if.DIN = 4'h0;
    lo_if.ENB_LD = 1'b0; hi_if.ENB_LD = 1'b0;
    tick();
    lo_if.ENB_LD = 1'b1; hi_if.ENB_LD = 1'b1;
    check("cas_load", {hi_if.Q, lo_if.Q}, 8'h0E);
    check("cas_rco_pre", lo_if.RCO_N, 1);
    lo_if.ENP_N = 1'b0; hi_if.ENP_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("cas_q%0d", i), {hi_if.Q, lo_if.Q}, exp_cas[i]);
      if (i == 0) check("cas_lo_rco", lo_if.RCO_N, 0);
    end
    check("cas_hi_rco", hi_if.RCO_N, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
